// File: rtl/valu_seq.sv
// valu_seq: issues one wavefront-wide op over several passes to a narrow lane-ALU array,
// skipping all-inactive passes and merging per-pass results into wavefront registers.
module valu_seq #(
    parameter int WAVE_LANES = 16,
    parameter int PHYS_LANES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WAVE_LANES*32-1:0]   alu_source1_data,
    input  logic [WAVE_LANES*32-1:0]   alu_source2_data,
    input  logic [WAVE_LANES*32-1:0]   alu_source3_data,
    input  logic [WAVE_LANES-1:0]      alu_source_vcc_value,
    input  logic [WAVE_LANES-1:0]      alu_source_exec_value,
    input  logic [31:0]                alu_control,
    input  logic                       alu_start,
    output logic                       busy,
    output logic [WAVE_LANES*32-1:0]   alu_vgpr_dest_data,
    output logic [WAVE_LANES-1:0]      alu_sgpr_dest_data,
    output logic [WAVE_LANES-1:0]      alu_dest_vcc_value,
    output logic [WAVE_LANES-1:0]      alu_dest_exec_value,
    output logic                       valu_done,
    output logic [PHYS_LANES*32-1:0]   lane_source1_data,
    output logic [PHYS_LANES*32-1:0]   lane_source2_data,
    output logic [PHYS_LANES*32-1:0]   lane_source3_data,
    output logic [PHYS_LANES-1:0]      lane_source_vcc_value,
    output logic [PHYS_LANES-1:0]      lane_source_exec_value,
    output logic [31:0]                lane_control,
    output logic                       lane_start,
    input  logic [PHYS_LANES*32-1:0]   lane_vgpr_dest_data,
    input  logic [PHYS_LANES-1:0]      lane_sgpr_dest_data,
    input  logic [PHYS_LANES-1:0]      lane_dest_vcc_value,
    input  logic [PHYS_LANES-1:0]      lane_done
);
    localparam int PASSES = WAVE_LANES / PHYS_LANES;
    localparam int PW = PASSES > 1 ? $clog2(PASSES) : 1;
    localparam int WW = WAVE_LANES * 32;
    localparam int SW = PHYS_LANES * 32;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [WW-1:0] src1_q, src1_d, src2_q, src2_d, src3_q, src3_d;
    logic [WW-1:0] vgpr_q, vgpr_d, out_vgpr_q, out_vgpr_d;
    logic [WAVE_LANES-1:0] vcc_q, vcc_d, exec_q, exec_d;
    logic [WAVE_LANES-1:0] sgpr_q, sgpr_d, dvcc_q, dvcc_d, out_sgpr_q, out_sgpr_d, out_vcc_q, out_vcc_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [PHYS_LANES-1:0] exec_sl, vcc_sl, m_sgpr, m_vcc;
    logic [SW-1:0] m_vgpr;
    logic pass_end, last;

    assign exec_sl = exec_q[p_q*PHYS_LANES +: PHYS_LANES];
    assign vcc_sl = vcc_q[p_q*PHYS_LANES +: PHYS_LANES];
    assign last = p_q == PW'(PASSES - 1);
    // a skipped pass merges exactly like a pass whose lanes are all inactive
    assign pass_end = state_q == ISSUE ? exec_sl == '0 : state_q == WAIT && &(lane_done | ~exec_sl);
    assign m_sgpr = lane_sgpr_dest_data & exec_sl;
    assign m_vcc = (lane_dest_vcc_value & exec_sl) | (vcc_sl & ~exec_sl);

    always_comb begin
        m_vgpr = '0;
        for (int j = 0; j < PHYS_LANES; j++)
            m_vgpr[j*32 +: 32] = exec_sl[j] ? lane_vgpr_dest_data[j*32 +: 32] : 32'd0;
    end

    always_comb begin
        state_d = state_q;
        p_d = p_q;
        src1_d = src1_q;
        src2_d = src2_q;
        src3_d = src3_q;
        vcc_d = vcc_q;
        exec_d = exec_q;
        ctrl_d = ctrl_q;
        vgpr_d = vgpr_q;
        sgpr_d = sgpr_q;
        dvcc_d = dvcc_q;
        out_vgpr_d = out_vgpr_q;
        out_sgpr_d = out_sgpr_q;
        out_vcc_d = out_vcc_q;
        if (state_q == IDLE && alu_start && alu_control != '0) begin
            src1_d = alu_source1_data;
            src2_d = alu_source2_data;
            src3_d = alu_source3_data;
            vcc_d = alu_source_vcc_value;
            exec_d = alu_source_exec_value;
            ctrl_d = alu_control;
            vgpr_d = '0;
            sgpr_d = '0;
            dvcc_d = '0;
            out_vgpr_d = '0;
            out_sgpr_d = '0;
            out_vcc_d = '0;
            p_d = '0;
            state_d = ISSUE;
        end else if (pass_end) begin
            vgpr_d[p_q*SW +: SW] = m_vgpr;
            sgpr_d[p_q*PHYS_LANES +: PHYS_LANES] = m_sgpr;
            dvcc_d[p_q*PHYS_LANES +: PHYS_LANES] = m_vcc;
            p_d = last ? p_q : p_q + PW'(1);
            state_d = last ? DONE : ISSUE;
            out_vgpr_d = last ? vgpr_d : out_vgpr_q;
            out_sgpr_d = last ? sgpr_d : out_sgpr_q;
            out_vcc_d = last ? dvcc_d : out_vcc_q;
        end else begin
            state_d = state_q == ISSUE ? WAIT : state_q == DONE ? IDLE : state_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            p_q <= '0;
            src1_q <= '0;
            src2_q <= '0;
            src3_q <= '0;
            vcc_q <= '0;
            exec_q <= '0;
            ctrl_q <= '0;
            vgpr_q <= '0;
            sgpr_q <= '0;
            dvcc_q <= '0;
            out_vgpr_q <= '0;
            out_sgpr_q <= '0;
            out_vcc_q <= '0;
        end else begin
            state_q <= state_d;
            p_q <= p_d;
            src1_q <= src1_d;
            src2_q <= src2_d;
            src3_q <= src3_d;
            vcc_q <= vcc_d;
            exec_q <= exec_d;
            ctrl_q <= ctrl_d;
            vgpr_q <= vgpr_d;
            sgpr_q <= sgpr_d;
            dvcc_q <= dvcc_d;
            out_vgpr_q <= out_vgpr_d;
            out_sgpr_q <= out_sgpr_d;
            out_vcc_q <= out_vcc_d;
        end
    end

    assign busy = state_q != IDLE;
    assign valu_done = state_q == DONE;
    assign lane_start = state_q == ISSUE && exec_sl != '0;
    assign lane_control = ctrl_q;
    assign lane_source1_data = src1_q[p_q*SW +: SW];
    assign lane_source2_data = src2_q[p_q*SW +: SW];
    assign lane_source3_data = src3_q[p_q*SW +: SW];
    assign lane_source_vcc_value = vcc_sl;
    assign lane_source_exec_value = exec_sl;
    assign alu_vgpr_dest_data = out_vgpr_q;
    assign alu_sgpr_dest_data = out_sgpr_q;
    assign alu_dest_vcc_value = out_vcc_q;
    assign alu_dest_exec_value = exec_q;
endmodule

// File: tb/tb_valu_seq.sv
// tb_valu_seq: scoreboard bench for valu_seq with a behavioural lane-array model and
// a wavefront-level reference model of results and latency.
module tb_valu_seq;
    localparam int WL = 16, PL = 4, NP = WL / PL, SW = PL * 32, NEVER = 100000;

    logic clk = 0, rst = 1;
    logic [WL*32-1:0] s1 = '0, s2 = '0, s3 = '0;
    logic [WL-1:0] vcc_in = '0, exec_in = '0;
    logic [31:0] ctrl = '0;
    logic start = 0;
    logic busy, done;
    logic [WL*32-1:0] vgpr_o;
    logic [WL-1:0] sgpr_o, vcc_o, exec_o;
    logic [SW-1:0] l_s1, l_s2, l_s3, l_vgpr;
    logic [PL-1:0] l_vcc_in, l_exec, l_sgpr, l_vcc, l_done;
    logic [31:0] l_ctrl;
    logic l_start;

    typedef struct { logic [WL*32-1:0] vgpr; logic [WL-1:0] sgpr, vcc, exec; int e0, lat; } exp_t;
    typedef struct { logic [SW-1:0] s1; logic [PL-1:0] ex; logic [31:0] ct; } sl_t;
    exp_t exp_q[$], last_e, mon_e;
    sl_t sl_q[$], mon_s;
    int total = 0, bad = 0;

    valu_seq #(.WAVE_LANES(WL), .PHYS_LANES(PL)) dut (
        .clk(clk), .rst(rst),
        .alu_source1_data(s1), .alu_source2_data(s2), .alu_source3_data(s3),
        .alu_source_vcc_value(vcc_in), .alu_source_exec_value(exec_in),
        .alu_control(ctrl), .alu_start(start), .busy(busy),
        .alu_vgpr_dest_data(vgpr_o), .alu_sgpr_dest_data(sgpr_o),
        .alu_dest_vcc_value(vcc_o), .alu_dest_exec_value(exec_o), .valu_done(done),
        .lane_source1_data(l_s1), .lane_source2_data(l_s2), .lane_source3_data(l_s3),
        .lane_source_vcc_value(l_vcc_in), .lane_source_exec_value(l_exec),
        .lane_control(l_ctrl), .lane_start(l_start),
        .lane_vgpr_dest_data(l_vgpr), .lane_sgpr_dest_data(l_sgpr),
        .lane_dest_vcc_value(l_vcc), .lane_done(l_done)
    );

    always #5 clk = ~clk;

    // lane array model: result = src1+src2, sgpr = sum lsb, vcc = src3 lsb, lane j done dly[j] cycles after start
    int cyc = 0, st_cyc = 0, dly[PL];
    logic armed = 0;
    logic [SW-1:0] m1 = '0, m2 = '0, m3 = '0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (l_start) begin
        armed <= 1;
        st_cyc <= cyc;
        m1 <= l_s1;
        m2 <= l_s2;
        m3 <= l_s3;
    end
    always_comb begin
        l_vgpr = '0;
        l_sgpr = '0;
        l_vcc = '0;
        l_done = '0;
        for (int j = 0; j < PL; j++) begin
            l_vgpr[j*32 +: 32] = m1[j*32 +: 32] + m2[j*32 +: 32];
            l_sgpr[j] = m1[j*32] ^ m2[j*32];
            l_vcc[j] = m3[j*32];
            l_done[j] = armed && cyc >= st_cyc + dly[j];
        end
    end

    task automatic chk(input string name, input logic [WL*32-1:0] act, input logic [WL*32-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WL*32-1:0] rnd_wave();
        logic [WL*32-1:0] r;
        for (int i = 0; i < WL; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // reference: per-lane results from exec, latency = sum of pass costs + DONE cycle
    task automatic start_op(input logic [WL*32-1:0] a, input logic [WL*32-1:0] b, input logic [WL*32-1:0] c,
                            input logic [WL-1:0] v, input logic [WL-1:0] ex, input logic [31:0] ct);
        exp_t e;
        sl_t s;
        int mx;
        logic [31:0] sum;
        e.lat = 1;
        for (int i = 0; i < WL; i++) begin
            sum = a[i*32 +: 32] + b[i*32 +: 32];
            e.vgpr[i*32 +: 32] = ex[i] ? sum : 32'd0;
            e.sgpr[i] = ex[i] & sum[0];
            e.vcc[i] = ex[i] ? c[i*32] : v[i];
        end
        for (int p = 0; p < NP; p++) begin
            if (ex[p*PL +: PL] == '0) e.lat += 1;
            else begin
                mx = 0;
                for (int l = 0; l < PL; l++) if (ex[p*PL+l] && dly[l] > mx) mx = dly[l];
                e.lat += 1 + mx;
                s.s1 = a[p*SW +: SW];
                s.ex = ex[p*PL +: PL];
                s.ct = ct;
                sl_q.push_back(s);
            end
        end
        e.exec = ex;
        @(negedge clk);
        s1 = a; s2 = b; s3 = c; vcc_in = v; exec_in = ex; ctrl = ct; start = 1;
        e.e0 = cyc + 1;
        exp_q.push_back(e);
        last_e = e;
        @(negedge clk);
        start = 0;
    endtask

    task automatic finish_op();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("op_timeout", {511'd0, busy}, '0);
        chk("hold_vgpr", vgpr_o, last_e.vgpr);
        chk("hold_vcc", {496'd0, vcc_o}, {496'd0, last_e.vcc});
    endtask

    always @(negedge clk) begin
        if (l_start) begin
            if (sl_q.size() == 0) begin
                total++; bad++;
                $display("FAIL lane_start: unexpected pulse at cycle %0d", cyc);
            end else begin
                mon_s = sl_q.pop_front();
                chk("slice_src1", {384'd0, l_s1}, {384'd0, mon_s.s1});
                chk("slice_exec", {508'd0, l_exec}, {508'd0, mon_s.ex});
                chk("lane_ctrl", {480'd0, l_ctrl}, {480'd0, mon_s.ct});
            end
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL valu_done: unexpected pulse at cycle %0d", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("vgpr", vgpr_o, mon_e.vgpr);
                chk("sgpr", {496'd0, sgpr_o}, {496'd0, mon_e.sgpr});
                chk("vcc", {496'd0, vcc_o}, {496'd0, mon_e.vcc});
                chk("exec", {496'd0, exec_o}, {496'd0, mon_e.exec});
                chk("latency", WL*32'(cyc - mon_e.e0 + 1), WL*32'(mon_e.lat));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [WL*32-1:0] idx, c100;
        logic [WL-1:0] ex;
        for (int i = 0; i < WL; i++) begin
            idx[i*32 +: 32] = i;
            c100[i*32 +: 32] = 100;
        end
        dly = '{1, 1, 1, 1};
        repeat (2) @(negedge clk);
        chk("rst_busy", {511'd0, busy}, '0);
        chk("rst_vgpr", vgpr_o, '0);
        chk("rst_flags", {464'd0, sgpr_o, vcc_o, exec_o}, '0);
        chk("rst_lane", {478'd0, done, l_start, l_ctrl}, '0);
        rst = 0;
        // all lanes active, then a single middle slice, then no lanes at all
        start_op(idx, c100, rnd_wave(), 16'h1234, 16'hFFFF, 32'h11);
        finish_op();
        start_op(idx, c100, rnd_wave(), 16'h0F0F, 16'h00F0, 32'h22);
        finish_op();
        start_op(rnd_wave(), rnd_wave(), rnd_wave(), 16'hA5A5, 16'h0000, 32'h33);
        finish_op();
        // zero control is not a start
        @(negedge clk);
        ctrl = '0; start = 1;
        @(negedge clk);
        chk("ctrl0_busy", {511'd0, busy}, '0);
        start = 0;
        repeat (3) @(negedge clk);
        // lane 3 stalls; start strobes during WAIT are ignored
        dly = '{1, 1, 1, 7};
        start_op(idx, c100, rnd_wave(), 16'hFFFF, 16'h000F, 32'h44);
        repeat (2) @(negedge clk);
        s1 = rnd_wave(); exec_in = 16'hFFFF; ctrl = 32'h99; start = 1;
        @(negedge clk);
        chk("wait_busy", {511'd0, busy}, 512'd1);
        start = 0;
        finish_op();
        // inactive lanes never finishing must not block the pass
        dly = '{1, 1, NEVER, NEVER};
        start_op(rnd_wave(), rnd_wave(), rnd_wave(), $urandom, 16'h0003, 32'h55);
        finish_op();
        // asynchronous reset in WAIT of pass 2
        dly = '{1, 1, 1, 1};
        start_op(idx, c100, rnd_wave(), 16'hFFFF, 16'hFFFF, 32'h66);
        while (cyc < last_e.e0 + 5) @(negedge clk);
        #1 rst = 1;
        #1;
        chk("arst_busy", {510'd0, busy, done}, '0);
        chk("arst_vgpr", vgpr_o, '0);
        chk("arst_flags", {464'd0, sgpr_o, vcc_o, exec_o}, '0);
        chk("arst_lane", {351'd0, l_start, l_ctrl, l_s1}, '0);
        exp_q.delete();
        sl_q.delete();
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        start_op(idx, c100, rnd_wave(), 16'h1234, 16'hFFFF, 32'h11);
        finish_op();
        // randomized operations
        for (int k = 0; k < 30; k++) begin
            for (int l = 0; l < PL; l++) dly[l] = $urandom_range(1, 4);
            for (int p = 0; p < NP; p++) ex[p*PL +: PL] = $urandom_range(0, 3) == 0 ? 4'h0 : 4'($urandom);
            start_op(rnd_wave(), rnd_wave(), rnd_wave(), 16'($urandom), ex, $urandom | 32'd1);
            finish_op();
        end
        repeat (3) @(negedge clk);
        chk("exp_q_empty", 512'(exp_q.size()), '0);
        chk("slice_q_empty", 512'(sl_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
